// File: rtl/cpu_clk_pkg.sv
// cpu_clk_pkg: shared FSM state encoding and default parameters for the
// processor clock-enable controller.
package cpu_clk_pkg;
    typedef enum logic [1:0] {S_IDLE, S_HELD, S_RUN} state_t;
    localparam int DB_TICKS_DEF = 4;
    localparam int RUN_DIV_DEF  = 1;
    localparam int CNT_W_DEF    = 16;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: 2-flop synchroniser followed by a tick-sampled debouncer that
// accepts a new level only after DB_TICKS consecutive disagreeing samples.
module sync_debounce
    import cpu_clk_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_db
);
    localparam int CW = $clog2(DB_TICKS);
    logic          r_s1, r_s2, r_db;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (i_tick) begin
                if (r_s2 == r_db) r_cnt <= '0;
                else if (r_cnt == CW'(DB_TICKS - 1)) begin
                    r_db  <= r_s2;
                    r_cnt <= '0;
                end else r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign o_db = r_db;
endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: step/run clock-enable controller issuing one-clock cpu_en pulses.
// Define STEP_COUNT_EN to build the step_count pulse counter (else tied to 0).
module cpu_step_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEF,
    parameter int RUN_DIV  = RUN_DIV_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             btn_step,
    input  logic             sw_run,
    output logic             cpu_en,
    output logic             running,
    output logic [CNT_W-1:0] step_count
);
    localparam int RW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
    state_t          r_state, w_next;
    logic            w_db_step, w_db_run, w_pulse, w_run_hit, r_cpu_en, r_running;
    logic [RW-1:0]   r_rcnt;

    sync_debounce #(.DB_TICKS(DB_TICKS)) u_db_step (
        .clock(clock), .reset(reset), .i_tick(tick), .i_raw(btn_step), .o_db(w_db_step)
    );
    sync_debounce #(.DB_TICKS(DB_TICKS)) u_db_run (
        .clock(clock), .reset(reset), .i_tick(tick), .i_raw(sw_run), .o_db(w_db_run)
    );

    assign w_run_hit = tick && (r_rcnt == RW'(RUN_DIV - 1));

    // Run wins over step; leaving run with the button down parks in S_HELD.
    always_comb begin
        w_next  = r_state;
        w_pulse = 1'b0;
        case (r_state)
            S_IDLE: if (w_db_run) w_next = S_RUN;
                    else if (w_db_step) begin
                        w_next  = S_HELD;
                        w_pulse = 1'b1;
                    end
            S_HELD: if (w_db_run) w_next = S_RUN;
                    else if (!w_db_step) w_next = S_IDLE;
            S_RUN:  if (!w_db_run) w_next = w_db_step ? S_HELD : S_IDLE;
                    else w_pulse = w_run_hit;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cpu_en  <= 1'b0;
            r_running <= 1'b0;
            r_rcnt    <= '0;
        end else begin
            r_state   <= w_next;
            r_cpu_en  <= w_pulse;
            r_running <= (w_next == S_RUN);
            r_rcnt    <= (r_state != S_RUN) ? '0 : !tick ? r_rcnt : w_run_hit ? '0 : r_rcnt + 1'b1;
        end
    end

    assign cpu_en  = r_cpu_en;
    assign running = r_running;

`ifdef STEP_COUNT_EN
    logic [CNT_W-1:0] r_step_count;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_step_count <= '0;
        else if (w_pulse) r_step_count <= r_step_count + 1'b1;
    end
    assign step_count = r_step_count;
`else
    assign step_count = '0;
`endif
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: segment table, hand-written corner sequences and random
// stimulus, each cycle compared with a behavioural model of the controller.
module tb_cpu_step_ctrl;
    localparam int DB_TICKS = 4;
    localparam int RUN_DIV  = 2;
    localparam int CNT_W    = 16;

    logic             clock, reset, tick, btn_step, sw_run;
    logic             cpu_en, running;
    logic [CNT_W-1:0] step_count;
    int               n_tests = 0, n_fail = 0, tcnt = 0, np = 0;
    logic             preload = 1'b0;

    cpu_step_ctrl #(.DB_TICKS(DB_TICKS), .RUN_DIV(RUN_DIV), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .tick(tick), .btn_step(btn_step), .sw_run(sw_run),
        .cpu_en(cpu_en), .running(running), .step_count(step_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial tick = 1'b0;
    always @(negedge clock) begin
        tcnt = (tcnt == 3) ? 0 : tcnt + 1;
        tick = (tcnt == 0);
    end

    // Model: synchronised level seen 2 clocks late, accepted after a streak of
    // DB_TICKS disagreeing tick samples; run pulses on every RUN_DIV-th tick in run.
    logic             sb0, sb1, sr0, sr1, db_b, db_r, m_en, m_running;
    int               st_b, st_r, mode, run_ticks;
    logic [CNT_W-1:0] m_cnt;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            {sb0, sb1, sr0, sr1, db_b, db_r, m_en, m_running} = '0;
            st_b = 0; st_r = 0; mode = 0; run_ticks = 0; m_cnt = '0;
        end else begin
            m_en = 1'b0;
            if (mode == 0) begin
                if (db_r) begin mode = 2; run_ticks = 0; end
                else if (db_b) begin mode = 1; m_en = 1'b1; end
            end else if (mode == 1) begin
                if (db_r) begin mode = 2; run_ticks = 0; end
                else if (!db_b) mode = 0;
            end else if (!db_r) mode = db_b ? 1 : 0;
            else if (tick) begin
                run_ticks++;
                m_en = (run_ticks % RUN_DIV == 0);
            end
            if (m_en) m_cnt = m_cnt + 1'b1;
            if (preload) m_cnt = '1;
            m_running = (mode == 2);
            if (tick) begin
                st_b = (sb1 != db_b) ? st_b + 1 : 0;
                if (st_b == DB_TICKS) begin db_b = sb1; st_b = 0; end
                st_r = (sr1 != db_r) ? st_r + 1 : 0;
                if (st_r == DB_TICKS) begin db_r = sr1; st_r = 0; end
            end
            sb1 = sb0; sb0 = btn_step;
            sr1 = sr0; sr0 = sw_run;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic cyc(input logic run, input logic btn);
        sw_run   = run;
        btn_step = btn;
        @(negedge clock);
        if (cpu_en) np++;
        chk("cpu_en", int'(cpu_en), int'(m_en));
        chk("running", int'(running), int'(m_running));
`ifdef STEP_COUNT_EN
        chk("step_count", int'(step_count), int'(m_cnt));
`else
        chk("step_count", int'(step_count), 0);
`endif
    endtask

    typedef struct {
        logic run;
        logic btn;
        int   clocks;
        int   lo;
        int   hi;
        logic run_end;
    } seg_t;
    seg_t segs[11];

    initial begin
        segs[0]  = '{1'b0, 1'b1, 40,  1,  1,  1'b0};
        segs[1]  = '{1'b0, 1'b0, 40,  0,  0,  1'b0};
        segs[2]  = '{1'b1, 1'b0, 200, 21, 25, 1'b1};
        segs[3]  = '{1'b0, 1'b0, 40,  1,  3,  1'b0};
        segs[4]  = '{1'b0, 1'b0, 40,  0,  0,  1'b0};
        segs[5]  = '{1'b1, 1'b1, 100, 8,  11, 1'b1};
        segs[6]  = '{1'b0, 1'b1, 60,  1,  3,  1'b0};
        segs[7]  = '{1'b0, 1'b1, 40,  0,  0,  1'b0};
        segs[8]  = '{1'b0, 1'b0, 40,  0,  0,  1'b0};
        segs[9]  = '{1'b0, 1'b1, 40,  1,  1,  1'b0};
        segs[10] = '{1'b0, 1'b0, 40,  0,  0,  1'b0};

        reset = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1);
        chk("reset_cpu_en", int'(cpu_en), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_step_count", int'(step_count), 0);
        reset = 1'b0;

        for (int s = 0; s < 11; s++) begin
            np = 0;
            for (int c = 0; c < segs[s].clocks; c++) cyc(segs[s].run, segs[s].btn);
            chk_range($sformatf("seg%0d_pulses", s), np, segs[s].lo, segs[s].hi);
            chk($sformatf("seg%0d_running", s), int'(running), int'(segs[s].run_end));
        end

        np = 0;
        for (int c = 0; c < 60; c++) cyc(1'b0, (c / 6) % 2 == 0);
        chk("bounce_pulses", np, 0);
        np = 0;
        for (int c = 0; c < 40; c++) cyc(1'b0, 1'b1);
        chk("bounce_settle_pulses", np, 1);
        for (int c = 0; c < 40; c++) cyc(1'b0, 1'b0);

        for (int c = 0; c < 60; c++) cyc(1'b1, 1'b0);
        chk("pre_reset_running", int'(running), 1);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) cyc(1'b1, 1'b0);
        chk("mid_reset_running", int'(running), 0);
        chk("mid_reset_step_count", int'(step_count), 0);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) cyc(1'b0, 1'b0);

`ifdef STEP_COUNT_EN
        preload = 1'b1;
        force dut.r_step_count = '1;
        cyc(1'b0, 1'b0);
        preload = 1'b0;
        release dut.r_step_count;
        cyc(1'b0, 1'b0);
        chk("preload_count", int'(step_count), 16'hFFFF);
`endif
        for (int c = 0; c < 40; c++) cyc(1'b0, 1'b1);
        for (int c = 0; c < 40; c++) cyc(1'b0, 1'b0);
        chk("wrap_count", int'(step_count), 0);

        for (int s = 0; s < 40; s++) begin
            logic r, b;
            int   len;
            r   = ($urandom_range(0, 3) == 0);
            b   = $urandom_range(0, 1) == 1;
            len = $urandom_range(1, 50);
            for (int c = 0; c < len; c++) cyc(r, b);
        end
        for (int c = 0; c < 40; c++) cyc(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
